// File: rtl/tensor_pe_array_pkg.sv
// tensor_pkg: shared widths and the tile bundle for the 2x2 PE array.
// Holds operand width, default accumulator width and tile_t.
package tensor_pkg;

  localparam int OP_W      = 8;
  localparam int ACC_W_DEF = 32;

  typedef logic signed [OP_W-1:0]      op_t;
  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  typedef struct packed {
    acc_t c11;
    acc_t c12;
    acc_t c21;
    acc_t c22;
  } tile_t;

endpackage

// File: rtl/tensor_pe_array_if.sv
// Tile output stream: valid/ready handshake plus the four head results.
// master drives valid and c*, slave drives ready.
interface tensor_pe_array_if #(
  parameter int ACC_W = 32
);

  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_c11;
  logic [ACC_W-1:0] out_c12;
  logic [ACC_W-1:0] out_c21;
  logic [ACC_W-1:0] out_c22;

  modport master (
    output out_valid,
    output out_c11,
    output out_c12,
    output out_c21,
    output out_c22,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_c11,
    input  out_c12,
    input  out_c21,
    input  out_c22,
    output out_ready
  );

endinterface

// File: rtl/tensor_pe_array_pe.sv
// tensor_pe: one MAC cell (8x8 signed multiply, accumulate, push capture).
// Ports: clk, reset_n, a, b, run, push, clear -> cap (comb), stage (reg).
// TENSOR_SATURATE_EN: saturating accumulate/capture, else wrap.
module tensor_pe
  import tensor_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  op_t              a,
  input  op_t              b,
  input  logic             run,
  input  logic             push,
  input  logic             clear,
  output logic [ACC_W-1:0] cap,
  output logic [ACC_W-1:0] stage
);

  localparam int PW = 2 * OP_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  assign prod   = a * b;
  assign prod_x = {{(ACC_W-PW){prod[PW-1]}}, prod};

`ifdef TENSOR_SATURATE_EN
  logic signed [ACC_W:0] wide;

  assign wide = {acc[ACC_W-1], acc}
              + {prod_x[ACC_W-1], prod_x};

  // Top two bits disagree only when the sum left the signed range.
  always_comb begin
    sum = wide[ACC_W-1:0];
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sum = wide[ACC_W]
          ? {1'b1, {(ACC_W-1){1'b0}}}
          : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = acc + prod_x;
`endif

  assign cap = run ? sum : acc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc   <= '0;
      stage <= '0;
    end else if (clear) begin
      acc   <= '0;
      stage <= '0;
    end else if (push) begin
      stage <= cap;
      acc   <= '0;
    end else if (run) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/tensor_pe_array.sv
// tensor_pe_array: 2x2 output-stationary systolic array with tile FIFO.
// Ports: clk, reset_n, a1X/a2X/bX1/bX2, run, push11/pushedge/push22,
// clear, tile_out (out_valid/out_ready/out_c*), overflow, tile_count.
// Optional TENSOR_SATURATE_EN selects saturating arithmetic in the PEs.
module tensor_pe_array
  import tensor_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  op_t                a1X,
  input  op_t                a2X,
  input  op_t                bX1,
  input  op_t                bX2,
  input  logic               run,
  input  logic               push11,
  input  logic               pushedge,
  input  logic               push22,
  input  logic               clear,
  tensor_pe_array_if.master  tile_out,
  output logic               overflow,
  output logic [31:0]        tile_count
);

  localparam int TW = 4 * ACC_W;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  op_t              a1_d;
  op_t              a2_d;
  op_t              b1_d;
  op_t              b2_d;
  op_t              pa [4];
  op_t              pb [4];
  logic [3:0]       push_v;
  logic [ACC_W-1:0] cap_v [4];
  logic [ACC_W-1:0] stg_v [4];

  logic [TW-1:0]    mem [FIFO_DEPTH];
  logic [TW-1:0]    last;
  logic [TW-1:0]    head;
  logic [TW-1:0]    wr_data;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             pop;
  logic             wr;
  logic             drop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Skew forwarding runs every cycle, independent of run/clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a1_d <= '0;
      a2_d <= '0;
      b1_d <= '0;
      b2_d <= '0;
    end else begin
      a1_d <= a1X;
      a2_d <= a2X;
      b1_d <= bX1;
      b2_d <= bX2;
    end
  end

  assign pa[0] = a1X;
  assign pb[0] = bX1;
  assign pa[1] = a1_d;
  assign pb[1] = bX2;
  assign pa[2] = a2X;
  assign pb[2] = b1_d;
  assign pa[3] = a2_d;
  assign pb[3] = b2_d;

  assign push_v = {push22, pushedge, pushedge, push11};

  for (genvar k = 0; k < 4; k++) begin : g_pe
    tensor_pe #(
      .ACC_W (ACC_W)
    ) u_pe (
      .clk     (clk),
      .reset_n (reset_n),
      .a       (pa[k]),
      .b       (pb[k]),
      .run     (run),
      .push    (push_v[k]),
      .clear   (clear),
      .cap     (cap_v[k]),
      .stage   (stg_v[k])
    );
  end

  // C11..C21 come from staging (old values if re-pushed this cycle);
  // C22 is the value being captured right now.
  assign wr_data = {stg_v[0], stg_v[1], stg_v[2], cap_v[3]};

  assign full = (count == CW'(FIFO_DEPTH));
  assign pop  = tile_out.out_valid && tile_out.out_ready;
  assign wr   = push22 && !clear && (!full || pop);
  assign drop = push22 && !clear && full && !pop;

  always_ff @(posedge clk) begin
    if (reset_n && wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      tile_count <= '0;
      last       <= '0;
    end else begin
      if (pop) begin
        rd_ptr     <= nxt(rd_ptr);
        tile_count <= tile_count + 32'd1;
        last       <= mem[rd_ptr];
      end
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr) begin
          wr_ptr <= nxt(wr_ptr);
        end
        unique case ({wr, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Empty FIFO shows the most recently popped tile.
  assign head = tile_out.out_valid ? mem[rd_ptr] : last;

  assign tile_out.out_valid = (count != '0);
  assign tile_out.out_c11   = head[4*ACC_W-1 -: ACC_W];
  assign tile_out.out_c12   = head[3*ACC_W-1 -: ACC_W];
  assign tile_out.out_c21   = head[2*ACC_W-1 -: ACC_W];
  assign tile_out.out_c22   = head[ACC_W-1 -: ACC_W];

endmodule

// File: tb/tb_tensor_pe_array.sv
// Bench for tensor_pe_array: directed scenarios plus random traffic
// checked against a matrix/queue reference model.
module tb_tensor_pe_array;
  import tensor_pkg::*;

  localparam int W = 20;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  op_t         a1, a2, b1, b2;
  logic        run, p11, pe, p22, clr;
  logic        ovf;
  logic [31:0] tcnt;

  tensor_pe_array_if #(.ACC_W(W)) oif();

  tensor_pe_array #(
    .ACC_W      (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a1X        (a1),
    .a2X        (a2),
    .bX1        (b1),
    .bX2        (b2),
    .run        (run),
    .push11     (p11),
    .pushedge   (pe),
    .push22     (p22),
    .clear      (clr),
    .tile_out   (oif.master),
    .overflow   (ovf),
    .tile_count (tcnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, longint got, longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Reference model: four dot-product accumulators, staging, tile queue.
  longint      m_acc [4];
  longint      m_stg [4];
  longint      m_a1d, m_a2d, m_b1d, m_b2d;
  tile_t       q [$];
  tile_t       last;
  bit          m_ovf;
  int unsigned m_cnt;

  function automatic longint fit(longint s);
    longint lo, hi, m;
    lo = -(longint'(1) <<< (W - 1));
    hi = (longint'(1) <<< (W - 1)) - 1;
`ifdef TENSOR_SATURATE_EN
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    m = s & ((longint'(1) <<< W) - 1);
    if (m > hi) m = m - (longint'(1) <<< W);
    return m;
`endif
  endfunction

  task automatic model_step();
    longint p [4];
    longint cp [4];
    bit     ps [4];
    bit     pop, full;
    tile_t  t;
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        m_acc[k] = 0;
        m_stg[k] = 0;
      end
      m_a1d = 0; m_a2d = 0; m_b1d = 0; m_b2d = 0;
      q.delete();
      last  = '0;
      m_ovf = 0;
      m_cnt = 0;
      return;
    end
    p[0] = longint'(a1) * longint'(b1);
    p[1] = m_a1d * longint'(b2);
    p[2] = longint'(a2) * m_b1d;
    p[3] = m_a2d * m_b2d;
    ps[0] = p11; ps[1] = pe; ps[2] = pe; ps[3] = p22;
    for (int k = 0; k < 4; k++)
      cp[k] = run ? fit(m_acc[k] + p[k]) : m_acc[k];
    full = (q.size() == D);
    pop  = (q.size() != 0) && oif.out_ready;
    if (pop) begin
      last = q.pop_front();
      m_cnt++;
    end
    if (clr) begin
      for (int k = 0; k < 4; k++) begin
        m_acc[k] = 0;
        m_stg[k] = 0;
      end
      q.delete();
      m_ovf = 0;
    end else begin
      if (p22) begin
        t.c11 = acc_t'(m_stg[0]);
        t.c12 = acc_t'(m_stg[1]);
        t.c21 = acc_t'(m_stg[2]);
        t.c22 = acc_t'(cp[3]);
        if (full && !pop) m_ovf = 1;
        else q.push_back(t);
      end
      for (int k = 0; k < 4; k++) begin
        if (ps[k]) begin
          m_stg[k] = cp[k];
          m_acc[k] = 0;
        end else if (run) begin
          m_acc[k] = cp[k];
        end
      end
    end
    m_a1d = a1; m_a2d = a2; m_b1d = b1; m_b2d = b2;
  endtask

  task automatic compare();
    tile_t h;
    h = (q.size() != 0) ? q[0] : last;
    check("valid", oif.out_valid, longint'(q.size() != 0));
    check("c11", $signed(oif.out_c11), h.c11);
    check("c12", $signed(oif.out_c12), h.c12);
    check("c21", $signed(oif.out_c21), h.c21);
    check("c22", $signed(oif.out_c22), h.c22);
    check("ovf", ovf, m_ovf);
    check("tcnt", tcnt, m_cnt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic set_in(int x1, int x2, int y1, int y2,
                        bit r, bit s11, bit se, bit s22, bit c);
    a1 = op_t'(x1); a2 = op_t'(x2);
    b1 = op_t'(y1); b2 = op_t'(y2);
    run = r; p11 = s11; pe = se; p22 = s22; clr = c;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // A=[[1,2],[3,4]], B=I, skewed; ends with push22 so the tile lands.
  task automatic identity_tile();
    set_in(1, 0, 1, 0, 1, 0, 0, 0, 0); tick();
    set_in(2, 3, 0, 0, 1, 0, 0, 0, 0); tick();
    set_in(0, 4, 0, 1, 1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1, 1, 1, 0, 0); tick();
    check("id_lat0", oif.out_valid, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    check("id_lat1", oif.out_valid, 1);
    check("id_c11", $signed(oif.out_c11), 1);
    check("id_c12", $signed(oif.out_c12), 2);
    check("id_c21", $signed(oif.out_c21), 3);
    check("id_c22", $signed(oif.out_c22), 4);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_tile(bit r_ready);
    oif.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      set_in($urandom_range(255), $urandom_range(255),
             $urandom_range(255), $urandom_range(255),
             1, 0, 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 1, 1, 1, 0, 0); tick();
    oif.out_ready = r_ready;
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    oif.out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    oif.out_ready = 1'b0;
    do_reset();
    check("rst_valid", oif.out_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tcnt", tcnt, 0);
    check("rst_c11", $signed(oif.out_c11), 0);

    identity_tile();
    oif.out_ready = 1'b1; tick();
    oif.out_ready = 1'b0;

    // Negative operands
    set_in(-128, 0, -128, 0, 1, 0, 0, 0, 0); tick(); tick();
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    set_in(-128, 0, 127, 0, 1, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("neg_c11a", $signed(oif.out_c11), 32768);
    oif.out_ready = 1'b1; tick();
    check("neg_c11b", $signed(oif.out_c11), -16256);
    tick();
    oif.out_ready = 1'b0;

    // Back-pressure and drop
    do_reset();
    for (int i = 0; i < 3; i++) rand_tile(1'b0);
    check("bp_ovf", ovf, 1);
    check("bp_valid", oif.out_valid, 1);
    oif.out_ready = 1'b1; tick(); tick();
    oif.out_ready = 1'b0; tick();
    check("bp_tcnt", tcnt, 2);
    check("bp_empty", oif.out_valid, 0);

    // Full FIFO, push22 and pop together
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    rand_tile(1'b0);
    rand_tile(1'b0);
    rand_tile(1'b1);
    check("fp_ovf", ovf, 0);
    oif.out_ready = 1'b1; tick();
    check("fp_still", oif.out_valid, 1);
    tick();
    check("fp_empty", oif.out_valid, 0);
    oif.out_ready = 1'b0;

    // Accumulate toward the positive limit
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    for (int i = 0; i < 31; i++) begin
      set_in(-128, 0, -128, 0, 1, 0, 0, 0, 0); tick();
    end
    set_in(127, 0, 127, 0, 1, 0, 0, 0, 0); tick(); tick();
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef TENSOR_SATURATE_EN
    check("sat_c11", $signed(oif.out_c11), 524287);
`else
    check("sat_c11", $signed(oif.out_c11), -508414);
`endif
    oif.out_ready = 1'b1; tick();
    oif.out_ready = 1'b0;

    // Reset mid-tile discards partial sums
    set_in(50, -30, 70, 90, 1, 0, 0, 0, 0); tick(); tick();
    set_in(11, 22, 33, 44, 1, 1, 1, 0, 0); tick();
    do_reset();
    check("mr_valid", oif.out_valid, 0);
    identity_tile();
    oif.out_ready = 1'b1; tick();
    oif.out_ready = 1'b0;

    // Clear mid-tile with a full FIFO and overflow set
    for (int i = 0; i < 3; i++) rand_tile(1'b0);
    set_in(9, 8, 7, 6, 1, 1, 0, 0, 0); tick();
    set_in(5, 4, 3, 2, 1, 0, 1, 1, 1); tick();
    check("clr_valid", oif.out_valid, 0);
    check("clr_ovf", ovf, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    check("clr_zero", $signed(oif.out_c22), 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      reset_n = ($urandom_range(199) != 0);
      set_in($urandom_range(255), $urandom_range(255),
             $urandom_range(255), $urandom_range(255),
             $urandom_range(3) != 0,
             $urandom_range(7) == 0,
             $urandom_range(7) == 0,
             $urandom_range(5) == 0,
             $urandom_range(39) == 0);
      oif.out_ready = $urandom_range(2) == 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tensor_pe_array.md
TENSOR_PE_ARRAY -- requirements
Module: tensor_pe_array

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, listed first: clk input 1 (rising-edge clock); reset_n input 1 (synchronous, active-low).
REQ-002 The block SHALL have the parameter ACC_W, default 32, giving the accumulator and result width in bits.
REQ-003 The block SHALL have the parameter FIFO_DEPTH, default 2, giving the number of completed tiles buffered.
REQ-004 The block SHALL have the following ports after clk and reset_n, as name direction width meaning:
- a1X input 8: signed, row-1 operand, skewed.
- a2X input 8: signed, row-2 operand, skewed.
- bX1 input 8: signed, column-1 operand, skewed.
- bX2 input 8: signed, column-2 operand, skewed.
- run input 1: accumulate enable.
- push11 input 1: capture C11.
- pushedge input 1: capture C12 and C21.
- push22 input 1: capture C22 and complete the tile.
- clear input 1: clear accumulators, FIFO and overflow.
- out_valid output 1: a tile is available.
- out_ready input 1: the consumer accepts the tile.
- out_c11, out_c12, out_c21, out_c22 output ACC_W each: the head tile.
- overflow output 1: sticky flag, set when a tile is dropped.
- tile_count output 32: number of tiles accepted by the consumer.

Function
REQ-005 The array SHALL contain four PEs in a 2x2 output-stationary systolic array:
- PE11 uses (a1X, bX1).
- PE12 uses (a1X delayed 1 cycle, bX2).
- PE21 uses (a2X, bX1 delayed 1 cycle).
- PE22 uses (a2X delayed 1 cycle, bX2 delayed 1 cycle).
REQ-006 The forwarding registers SHALL update every cycle, regardless of run.
REQ-007 Each PE SHALL compute the product as 8x8 signed to 16 bits, sign-extended to ACC_W.
REQ-008 Each PE, when run=1, SHALL update acc <= acc + product, wrapping modulo 2^ACC_W.
REQ-009 When run=0, each PE SHALL hold acc.
REQ-010 On its push, a PE SHALL capture acc + (run ? product : 0) into staging and load acc <= 0 in the same cycle.
REQ-011 push11 SHALL stage C11, and pushedge SHALL stage C12 and C21.
REQ-012 On push22, the tile {staged C11, C12, C21, the C22 captured that cycle} SHALL be written to the FIFO on the following edge.
REQ-013 Latency from push22 to out_valid SHALL be 1 cycle when the FIFO was empty.
REQ-014 Handshake: a pop SHALL occur when out_valid && out_ready.
REQ-015 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-016 tile_count SHALL increment on each pop and wrap at 2^32.
REQ-017 FIFO full with push22 and no pop in the same cycle: the tile SHALL be dropped, overflow SHALL be set, and the FIFO contents SHALL be unchanged.
REQ-018 FIFO full with push22 and a pop in the same cycle: both SHALL occur and overflow SHALL NOT be set.
REQ-019 Empty FIFO: out_valid SHALL be 0 and out_* SHALL hold their last value.
REQ-020 push11 and push22 asserted in the same cycle SHALL be legal: the tile completes from the old staging, and C11 then restages for the next tile.
REQ-021 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 clear SHALL zero all accumulators, the staging registers and the FIFO occupancy, and clear overflow, on the next edge.
REQ-023 clear SHALL take priority over run and over any push in the same cycle.
REQ-024 clear SHALL NOT change tile_count.

Reset
REQ-025 With reset_n=0 at a clock edge, the block SHALL zero all accumulators, forwarding registers, staging registers, FIFO pointers and tile_count.
REQ-026 Reset SHALL drive out_valid=0, overflow=0 and out_c*=0.
REQ-027 Reset asserted mid-tile SHALL discard partial sums, and no tile SHALL be emitted for that tile.

Configuration
REQ-028 With TENSOR_SATURATE_EN defined, accumulation and push capture SHALL saturate to the signed ACC_W range, [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-029 With TENSOR_SATURATE_EN undefined, accumulation and push capture SHALL wrap two's complement.

Structure
REQ-030 The package tensor_pkg SHALL hold the operand width (8), the ACC_W default, and the typedef tile_t containing c11, c12, c21 and c22.
REQ-031 One PE SHALL be implemented as sub-module tensor_pe, instantiated four times; it SHALL contain the multiplier, the accumulator, the push capture and the saturation option.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Identity: A=[[1,2],[3,4]], B=I, skewed over 3 cycles, then push11/pushedge/push22 -> one tile {1,2,3,4}, out_valid 1 cycle after push22.
- Negative values: a=-128, b=-128 for 2 cycles, then push11 -> C11=32768; a=-128, b=127 for 1 cycle -> C11=-16256.
- Back-pressure: 3 tiles with out_ready=0 -> tiles 1-2 held stable, tile 3 dropped, overflow=1; then out_ready=1 -> 2 pops, tile_count=2.
- Full FIFO with push22 and pop in the same cycle -> overflow stays 0 and the FIFO stays full with the new tile last.
- Saturation: acc near 2^31-1 plus product 16129 -> with TENSOR_SATURATE_EN, 2147483647; without it, a negative wrapped value.
- reset_n low mid-accumulation, then a fresh tile -> result excludes earlier partial sums; clear mid-tile -> FIFO empty and overflow 0.
